// File: rtl/olp_scheduler_pkg.sv
// Shared constants, state encoding and helpers for the overlap-check scheduler.
package olp_scheduler_pkg;

  localparam int BMP_W       = 80;
  localparam int BMP_H       = 60;
  localparam int BMP_ENTRIES = BMP_W * BMP_H;

  localparam int POS_W  = 13;
  localparam int FPOS_W = 21;
  localparam int SIZE_W = 2;
  localparam int CNT_W  = 5;

  localparam logic [1:0] PASS_NONE    = 2'b00;
  localparam logic [1:0] PASS_REJECT  = 2'b10;
  localparam logic [1:0] PASS_ACCEPT  = 2'b11;
  localparam logic [1:0] SIZE_INVALID = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_READY = 3'd2,
    S_RUN   = 3'd3,
    S_WAIT  = 3'd4,
    S_STORE = 3'd5,
    S_DONE  = 3'd6
  } olp_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/olp_sync_fifo.sv
// Synchronous FIFO with extra-bit pointers; a push into a full FIFO is taken
// when a pop happens in the same cycle.
module olp_sync_fifo #(
  parameter int WIDTH = 15,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign wr_d    = do_push ? wr_q + PTR_ONE : wr_q;
  assign rd_d    = do_pop ? rd_q + PTR_ONE : rd_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end

  // Head is masked while empty so the outputs read zero out of reset.
  assign dout_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/olp_scheduler.sv
// Per-frame sequencer for the overlap-check unit: clears the bitmap, runs each
// buffered candidate through olp and queues accepted faces for display.
//
//   state | meaning
//   IDLE  | waiting for frame start
//   CLEAR | olp clearing the bitmap, no runs issued
//   READY | pop next candidate, or close the frame once end seen and drained
//   RUN   | one-cycle run strobe to olp
//   WAIT  | waiting for olp finish, bounded by timeout
//   STORE | push accepted face, stalls while face FIFO is full
//   DONE  | one-cycle frame-done pulse
module olp_scheduler
  import olp_scheduler_pkg::*;
#(
  parameter int CAND_DEPTH   = 8,
  parameter int FACE_DEPTH   = 16,
  parameter int CLEAR_CYCLES = BMP_ENTRIES + 2,
  parameter int TIMEOUT      = 64
) (
  input  logic              iClk,
  input  logic              iReset_n,
  input  logic              iFrame_Start,
  input  logic              iFrame_End,
  input  logic              iCand_Valid,
  output logic              oCand_Ready,
  input  logic [POS_W-1:0]  iCand_Pos,
  input  logic [SIZE_W-1:0] iCand_Size,
  output logic              oOlp_Run,
  output logic              oOlp_Set,
  output logic [POS_W-1:0]  oOlp_Position,
  output logic [SIZE_W-1:0] oOlp_Size,
  input  logic [1:0]        iOlp_Pass,
  input  logic              iOlp_Finish,
  input  logic [FPOS_W-1:0] iOlp_Face_Pos,
  input  logic [SIZE_W-1:0] iOlp_Size,
  output logic              oFace_Valid,
  input  logic              iFace_Ready,
  output logic [FPOS_W-1:0] oFace_Pos,
  output logic [SIZE_W-1:0] oFace_Size,
  output logic              oFrame_Done,
  output logic [CNT_W-1:0]  oFace_Count,
  output logic [1:0]        oErr
);

  localparam int CAND_W  = POS_W + SIZE_W;
  localparam int FACE_W  = FPOS_W + SIZE_W;
  localparam int TMR_MAX = (CLEAR_CYCLES > TIMEOUT) ? CLEAR_CYCLES : TIMEOUT;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  olp_state_e        state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic [SIZE_W-1:0] size_q, size_d;
  logic [1:0]        pass_q, pass_d, pass_now;
  logic [FPOS_W-1:0] fpos_q, fpos_d;
  logic [SIZE_W-1:0] fsize_q, fsize_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              fend_q, fend_d;
  logic              set_q, set_d;
  logic [1:0]        err_q, err_d;

  logic              cand_push, cand_pop, cand_full, cand_empty;
  logic [CAND_W-1:0] cand_dout;
  logic [POS_W-1:0]  cand_pos;
  logic [SIZE_W-1:0] cand_size;
  logic              face_push, face_pop, face_full, face_empty;
  logic [FACE_W-1:0] face_dout;

  assign {cand_size, cand_pos} = cand_dout;
  assign cand_push = iCand_Valid & ~cand_full;
  assign face_pop  = ~face_empty & iFace_Ready;
  // olp may drop oPass before raising oFinish, so fall back to the latched value.
  assign pass_now  = (iOlp_Pass != PASS_NONE) ? iOlp_Pass : pass_q;

  olp_sync_fifo #(.WIDTH(CAND_W), .DEPTH(CAND_DEPTH)) u_cand_fifo (
    .clk_i  (iClk),
    .rst_n_i(iReset_n),
    .push_i (cand_push),
    .din_i  ({iCand_Size, iCand_Pos}),
    .pop_i  (cand_pop),
    .dout_o (cand_dout),
    .full_o (cand_full),
    .empty_o(cand_empty)
  );

  olp_sync_fifo #(.WIDTH(FACE_W), .DEPTH(FACE_DEPTH)) u_face_fifo (
    .clk_i  (iClk),
    .rst_n_i(iReset_n),
    .push_i (face_push),
    .din_i  ({fsize_q, fpos_q}),
    .pop_i  (face_pop),
    .dout_o (face_dout),
    .full_o (face_full),
    .empty_o(face_empty)
  );

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    pos_d     = pos_q;
    size_d    = size_q;
    pass_d    = pass_q;
    fpos_d    = fpos_q;
    fsize_d   = fsize_q;
    count_d   = count_q;
    fend_d    = fend_q;
    err_d     = err_q;
    set_d     = 1'b0;
    cand_pop  = 1'b0;
    face_push = 1'b0;

    if (state_q != S_IDLE && iFrame_End)   fend_d   = 1'b1;
    if (state_q != S_IDLE && iFrame_Start) err_d[1] = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (iFrame_Start) begin
          set_d   = 1'b1;
          count_d = '0;
          fend_d  = 1'b0;
          tmr_d   = TMR_W'(CLEAR_CYCLES - 1);
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (tmr_q == '0) state_d = S_READY;
        else             tmr_d   = tmr_q - TMR_W'(1);
      end
      S_READY: begin
        if (!cand_empty) begin
          cand_pop = 1'b1;
          if (cand_size != SIZE_INVALID) begin
            pos_d   = cand_pos;
            size_d  = cand_size;
            state_d = S_RUN;
          end
        end else if (fend_q) begin
          state_d = S_DONE;
        end
      end
      S_RUN: begin
        tmr_d   = TMR_W'(TIMEOUT - 1);
        pass_d  = PASS_NONE;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (iOlp_Pass != PASS_NONE) begin
          pass_d  = iOlp_Pass;
          fpos_d  = iOlp_Face_Pos;
          fsize_d = iOlp_Size;
        end
        if (iOlp_Finish) begin
          state_d = (pass_now == PASS_ACCEPT) ? S_STORE : S_READY;
        end else if (tmr_q == '0) begin
          err_d[0] = 1'b1;
          state_d  = S_READY;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_STORE: begin
        if (!face_full || face_pop) begin
          face_push = 1'b1;
          count_d   = sat_inc(count_q);
          state_d   = S_READY;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      pos_q   <= '0;
      size_q  <= '0;
      pass_q  <= PASS_NONE;
      fpos_q  <= '0;
      fsize_q <= '0;
      count_q <= '0;
      fend_q  <= 1'b0;
      set_q   <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      pos_q   <= pos_d;
      size_q  <= size_d;
      pass_q  <= pass_d;
      fpos_q  <= fpos_d;
      fsize_q <= fsize_d;
      count_q <= count_d;
      fend_q  <= fend_d;
      set_q   <= set_d;
      err_q   <= err_d;
    end
  end

  assign oCand_Ready   = ~cand_full;
  assign oOlp_Run      = (state_q == S_RUN);
  assign oOlp_Set      = set_q;
  assign oOlp_Position = pos_q;
  assign oOlp_Size     = size_q;
  assign oFace_Valid   = ~face_empty;
  assign {oFace_Size, oFace_Pos} = face_dout;
  assign oFrame_Done   = (state_q == S_DONE);
  assign oFace_Count   = count_q;
  assign oErr          = err_q;

endmodule

// File: tb/tb_olp_scheduler.sv
// Directed bench for olp_scheduler with a behavioural olp responder driven from a
// per-run response queue (2'b00 in the queue means olp never finishes).
module tb_olp_scheduler;
  import olp_scheduler_pkg::*;

  localparam int CLR = BMP_ENTRIES + 2;

  logic        clk = 1'b0;
  logic        rst_n, frame_start, frame_end, cand_valid, face_ready;
  logic [12:0] cand_pos;
  logic [1:0]  cand_size;
  logic [1:0]  olp_pass, olp_size;
  logic        olp_finish;
  logic [20:0] olp_face_pos;

  logic        oCand_Ready, oOlp_Run, oOlp_Set, oFace_Valid, oFrame_Done;
  logic [12:0] oOlp_Position;
  logic [1:0]  oOlp_Size, oFace_Size, oErr;
  logic [20:0] oFace_Pos;
  logic [4:0]  oFace_Count;

  always #5 clk = ~clk;

  olp_scheduler dut (
    .iClk(clk), .iReset_n(rst_n), .iFrame_Start(frame_start), .iFrame_End(frame_end),
    .iCand_Valid(cand_valid), .oCand_Ready(oCand_Ready), .iCand_Pos(cand_pos),
    .iCand_Size(cand_size), .oOlp_Run(oOlp_Run), .oOlp_Set(oOlp_Set),
    .oOlp_Position(oOlp_Position), .oOlp_Size(oOlp_Size), .iOlp_Pass(olp_pass),
    .iOlp_Finish(olp_finish), .iOlp_Face_Pos(olp_face_pos), .iOlp_Size(olp_size),
    .oFace_Valid(oFace_Valid), .iFace_Ready(face_ready), .oFace_Pos(oFace_Pos),
    .oFace_Size(oFace_Size), .oFrame_Done(oFrame_Done), .oFace_Count(oFace_Count),
    .oErr(oErr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int run_cnt = 0, done_cnt = 0, set_cnt = 0, overlap_err = 0, hold_err = 0;
  logic [12:0] last_run_pos = '0;
  logic [1:0]  last_run_size = '0;
  logic [1:0]  resp_q[$];
  logic [20:0] face_pos_q[$];
  logic [1:0]  face_size_q[$];

  logic        m_busy = 1'b0;
  int          m_cnt = 0;
  logic [12:0] m_pos = '0;
  logic [1:0]  m_size = '0, m_resp = '0;

  function automatic logic [20:0] face_of(input logic [12:0] p);
    return {6'h15, 2'b00, p};
  endfunction

  // olp responder: pass/face data one cycle before finish, finish with pass dropped.
  always @(negedge clk) begin
    logic [1:0] r;
    olp_finish   = 1'b0;
    olp_pass     = 2'b00;
    olp_face_pos = '0;
    olp_size     = '0;
    if (!rst_n) begin
      m_busy = 1'b0;
    end else begin
      if (m_busy) begin
        if (oOlp_Position != m_pos || oOlp_Size != m_size) hold_err++;
        if (m_cnt == 1) begin
          olp_pass     = m_resp;
          olp_face_pos = face_of(m_pos);
          olp_size     = m_size;
        end
        if (m_cnt == 0) begin
          olp_finish = 1'b1;
          m_busy     = 1'b0;
        end else begin
          m_cnt--;
        end
      end
      if (oOlp_Run) begin
        run_cnt++;
        last_run_pos  = oOlp_Position;
        last_run_size = oOlp_Size;
        if (m_busy) overlap_err++;
        r = (resp_q.size() > 0) ? resp_q.pop_front() : PASS_ACCEPT;
        if (r != 2'b00) begin
          m_busy = 1'b1;
          m_cnt  = 3;
          m_pos  = oOlp_Position;
          m_size = oOlp_Size;
          m_resp = r;
        end
      end
      if (oFrame_Done) done_cnt++;
      if (oOlp_Set) set_cnt++;
      if (oFace_Valid && face_ready) begin
        face_pos_q.push_back(oFace_Pos);
        face_size_q.push_back(oFace_Size);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_cand(input logic [12:0] p, input logic [1:0] s);
    int guard = 0;
    cand_valid = 1'b1;
    cand_pos   = p;
    cand_size  = s;
    while (!oCand_Ready && guard < 2000) begin
      tick(1);
      guard++;
    end
    if (guard >= 2000) check("cand_ready_timeout", 32'(oCand_Ready), 32'd1);
    tick(1);
    cand_valid = 1'b0;
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
  endtask

  task automatic pulse_end();
    frame_end = 1'b1;
    tick(1);
    frame_end = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cand_ready"}, 32'(oCand_Ready), 32'd1);
    check({tag, "_olp_out"}, 32'({oOlp_Run, oOlp_Set, oOlp_Size, oOlp_Position}), 32'd0);
    check({tag, "_face_out"}, 32'({oFace_Valid, oFace_Size, oFace_Pos}), 32'd0);
    check({tag, "_done_cnt_err"}, 32'({oFrame_Done, oFace_Count, oErr}), 32'd0);
  endtask

  typedef struct {
    logic [12:0] pos;
    logic [1:0]  size;
    logic [1:0]  resp;
    int          exp_runs;
    int          exp_faces;
    int          exp_count;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int r0, d0, s0, fb;

    // cumulative expectations continue from the two candidates run earlier in frame 1
    vecs[0] = '{pos: 13'd200,  size: 2'd1, resp: PASS_REJECT, exp_runs: 3, exp_faces: 2, exp_count: 2};
    vecs[1] = '{pos: 13'd300,  size: 2'd3, resp: PASS_ACCEPT, exp_runs: 3, exp_faces: 2, exp_count: 2};
    vecs[2] = '{pos: 13'd301,  size: 2'd0, resp: PASS_ACCEPT, exp_runs: 4, exp_faces: 3, exp_count: 3};
    vecs[3] = '{pos: 13'd4799, size: 2'd2, resp: PASS_ACCEPT, exp_runs: 5, exp_faces: 4, exp_count: 4};
    vecs[4] = '{pos: 13'd0,    size: 2'd0, resp: PASS_REJECT, exp_runs: 6, exp_faces: 4, exp_count: 4};
    vecs[5] = '{pos: 13'd8191, size: 2'd1, resp: PASS_ACCEPT, exp_runs: 7, exp_faces: 5, exp_count: 5};

    rst_n = 1'b0; frame_start = 1'b0; frame_end = 1'b0;
    cand_valid = 1'b0; cand_pos = '0; cand_size = '0; face_ready = 1'b1;
    tick(3);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    tick(2);

    // ---------------- frame 1 ----------------
    pulse_start();
    check("set_pulse", 32'(oOlp_Set), 32'd1);
    tick(1);
    check("set_one_cycle", 32'(oOlp_Set), 32'd0);
    resp_q.push_back(PASS_ACCEPT);
    push_cand(13'd55, 2'd0);
    tick(4690);
    check("no_run_in_clear", run_cnt, 0);
    tick(160);
    check("buffered_run", run_cnt, 1);
    check("buffered_pos", 32'(last_run_pos), 32'd55);
    check("buffered_face_n", face_pos_q.size(), 1);
    if (face_pos_q.size() >= 1) check("buffered_face", 32'(face_pos_q[0]), 32'(face_of(13'd55)));

    // latency: push in an idle READY, Run two cycles later for exactly one cycle
    resp_q.push_back(PASS_ACCEPT);
    cand_valid = 1'b1; cand_pos = 13'd100; cand_size = 2'd0;
    tick(1);
    cand_valid = 1'b0;
    check("lat_c1_run", 32'(oOlp_Run), 32'd0);
    tick(1);
    check("lat_c2_run", 32'(oOlp_Run), 32'd1);
    check("lat_c2_pos", 32'(oOlp_Position), 32'd100);
    tick(1);
    check("run_one_cycle", 32'(oOlp_Run), 32'd0);
    tick(15);
    check("lat_runs", run_cnt, 2);
    check("lat_count", 32'(oFace_Count), 32'd1 + 32'd1);
    if (face_pos_q.size() >= 2)
      check("lat_face", 32'({face_size_q[1], face_pos_q[1]}), 32'({2'd0, face_of(13'd100)}));

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].size != SIZE_INVALID) resp_q.push_back(vecs[i].resp);
      push_cand(vecs[i].pos, vecs[i].size);
      tick(20);
      check($sformatf("vec%0d_runs", i), run_cnt, vecs[i].exp_runs);
      check($sformatf("vec%0d_faces", i), face_pos_q.size(), vecs[i].exp_faces);
      check($sformatf("vec%0d_count", i), 32'(oFace_Count), 32'(vecs[i].exp_count));
      if (vecs[i].size != SIZE_INVALID)
        check($sformatf("vec%0d_run_pos", i), 32'({last_run_size, last_run_pos}),
              32'({vecs[i].size, vecs[i].pos}));
      if (vecs[i].resp == PASS_ACCEPT && vecs[i].size != SIZE_INVALID &&
          face_pos_q.size() == vecs[i].exp_faces)
        check($sformatf("vec%0d_face", i), 32'({face_size_q[$], face_pos_q[$]}),
              32'({vecs[i].size, face_of(vecs[i].pos)}));
    end

    // back-to-back accept then reject
    resp_q.push_back(PASS_ACCEPT);
    resp_q.push_back(PASS_REJECT);
    push_cand(13'd400, 2'd1);
    push_cand(13'd401, 2'd2);
    tick(30);
    check("pair_runs", run_cnt, 9);
    check("pair_faces", face_pos_q.size(), 6);
    check("pair_count", 32'(oFace_Count), 32'd6);
    if (face_pos_q.size() >= 6) check("pair_face", 32'(face_pos_q[5]), 32'(face_of(13'd400)));
    check("pair_last_run", 32'(last_run_pos), 32'd401);

    d0 = done_cnt;
    pulse_end();
    tick(10);
    check("f1_done_pulse", done_cnt, d0 + 1);
    check("f1_done_low", 32'(oFrame_Done), 32'd0);

    // ---------------- frame 2 ----------------
    r0 = run_cnt;
    fb = face_pos_q.size();
    pulse_start();
    tick(1);
    check("f2_count_cleared", 32'(oFace_Count), 32'd0);
    tick(CLR + 5);

    face_ready = 1'b0;
    for (int i = 0; i < 17; i++) resp_q.push_back(PASS_ACCEPT);
    for (int i = 0; i < 17; i++) push_cand(13'(1000 + i), 2'(i % 3));
    tick(100);
    check("stall_runs", run_cnt, r0 + 17);
    check("stall_count", 32'(oFace_Count), 32'd16);
    check("stall_valid", 32'(oFace_Valid), 32'd1);
    check("stall_no_pop", face_pos_q.size(), fb);
    resp_q.push_back(PASS_REJECT);
    push_cand(13'd2000, 2'd0);
    tick(60);
    check("stall_no_run", run_cnt, r0 + 17);
    face_ready = 1'b1;
    tick(100);
    check("resume_count", 32'(oFace_Count), 32'd17);
    check("resume_runs", run_cnt, r0 + 18);
    check("resume_faces", face_pos_q.size(), fb + 17);
    if (face_pos_q.size() >= fb + 17)
      for (int i = 0; i < 17; i++)
        check($sformatf("resume_face%0d", i), 32'({face_size_q[fb + i], face_pos_q[fb + i]}),
              32'({2'(i % 3), face_of(13'(1000 + i))}));

    // olp never finishes; frame start during WAIT is an error and otherwise ignored
    s0 = set_cnt;
    resp_q.push_back(2'b00);
    push_cand(13'd500, 2'd1);
    tick(4);
    check("to_run", run_cnt, r0 + 19);
    tick(5);
    pulse_start();
    tick(1);
    check("busy_start_err", 32'(oErr), 32'd2);
    check("busy_start_no_set", set_cnt, s0);
    tick(30);
    check("to_not_early", 32'(oErr), 32'd2);
    tick(40);
    check("to_err", 32'(oErr), 32'd3);

    for (int i = 0; i < 15; i++) resp_q.push_back(PASS_ACCEPT);
    for (int i = 0; i < 15; i++) push_cand(13'(3000 + i), 2'd2);
    tick(150);
    check("sat_runs", run_cnt, r0 + 34);
    check("sat_count", 32'(oFace_Count), 32'd31);
    check("sat_faces", face_pos_q.size(), fb + 32);
    if (face_pos_q.size() >= fb + 32) begin
      check("after_to_face", 32'(face_pos_q[fb + 17]), 32'(face_of(13'd3000)));
      check("sat_last_face", 32'({face_size_q[fb + 31], face_pos_q[fb + 31]}),
            32'({2'd2, face_of(13'd3014)}));
    end
    d0 = done_cnt;
    pulse_end();
    tick(10);
    check("f2_done_pulse", done_cnt, d0 + 1);
    check("f2_err_sticky", 32'(oErr), 32'd3);

    // ---------------- frame 3: reset in the middle of CLEAR ----------------
    pulse_start();
    push_cand(13'd900, 2'd0);
    tick(100);
    rst_n = 1'b0;
    tick(1);
    check_reset_outputs("midclr");
    rst_n = 1'b1;
    tick(2);

    // ---------------- frame 4: end latched during CLEAR ----------------
    r0 = run_cnt;
    d0 = done_cnt;
    fb = face_pos_q.size();
    resp_q.delete();
    resp_q.push_back(PASS_ACCEPT);
    pulse_start();
    push_cand(13'd777, 2'd2);
    pulse_end();
    tick(CLR + 60);
    check("f4_runs", run_cnt, r0 + 1);
    check("f4_run_pos", 32'(last_run_pos), 32'd777);
    check("f4_faces", face_pos_q.size(), fb + 1);
    if (face_pos_q.size() >= fb + 1) check("f4_face", 32'(face_pos_q[fb]), 32'(face_of(13'd777)));
    check("f4_done", done_cnt, d0 + 1);
    check("f4_count", 32'(oFace_Count), 32'd1);

    check("run_overlap", overlap_err, 0);
    check("pos_hold", hold_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
